// File: rtl/imem_responder.sv
// Instruction-memory responder: in-order fixed-latency word reads plus a preload write port.
// Define IMEM_RANDOM_STALL_EN to add LFSR-driven imem_ready stalls.
module imem_responder #(
    parameter int unsigned LATENCY     = 1,
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'haaaaa000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] imem_addr,
    input  logic [3:0]  imem_rmask,
    output logic        imem_ready,
    output logic [31:0] imem_rdata,
    output logic        imem_resp,
    input  logic        load_we,
    input  logic [31:0] load_addr,
    input  logic [31:0] load_wdata,
    output logic        err
);

    localparam int unsigned IdxW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [32:0] Span = 33'(DEPTH_WORDS) * 33'd4;
    localparam logic [31:0] Nop  = 32'h00000013;

    logic [31:0]     mem_q [DEPTH_WORDS];
    logic [31:0]     req_off;
    logic [31:0]     load_off;
    logic [IdxW-1:0] req_idx;
    logic [IdxW-1:0] load_idx;
    logic            req_bad;
    logic            load_ok;
    logic            accept;
    logic            err_q;
    logic            err_d;

    logic            vld_q [LATENCY];
    logic [31:0]     dat_q [LATENCY];
    logic            bad_q [LATENCY];

    // Offsets wrap modulo 2^32, so addresses below BASE_ADDR land far out of range.
    always_comb begin
        req_off  = imem_addr - BASE_ADDR;
        load_off = load_addr - BASE_ADDR;
        req_idx  = req_off[IdxW+1:2];
        load_idx = load_off[IdxW+1:2];
        req_bad  = ({1'b0, req_off} >= Span) || (imem_addr[1:0] != 2'b00);
        load_ok  = load_we && ({1'b0, load_off} < Span) && (load_addr[1:0] == 2'b00);
        accept   = (|imem_rmask) && imem_ready && !rst;
        err_d    = err_q | (accept & req_bad);
    end

    // Contents survive reset; the nonblocking write makes same-cycle reads see the old word.
    always_ff @(posedge clk) begin
        if (load_ok) begin
            mem_q[load_idx] <= load_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
            for (int i = 0; i < int'(LATENCY); i++) begin
                vld_q[i] <= 1'b0;
                dat_q[i] <= '0;
                bad_q[i] <= 1'b0;
            end
        end else begin
            err_q    <= err_d;
            vld_q[0] <= accept;
            dat_q[0] <= accept ? mem_q[req_idx] : '0;
            bad_q[0] <= accept & req_bad;
            for (int i = 1; i < int'(LATENCY); i++) begin
                vld_q[i] <= vld_q[i-1];
                dat_q[i] <= dat_q[i-1];
                bad_q[i] <= bad_q[i-1];
            end
        end
    end

    always_comb begin
        imem_resp  = vld_q[LATENCY-1];
        imem_rdata = '0;
        if (vld_q[LATENCY-1]) begin
            imem_rdata = bad_q[LATENCY-1] ? Nop : dat_q[LATENCY-1];
        end
    end

    assign err = err_q;

`ifdef IMEM_RANDOM_STALL_EN
    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;

    // Right-shifting Galois form of x^16 + x^14 + x^13 + x^11 + 1.
    always_comb begin
        lfsr_d = {1'b0, lfsr_q[15:1]};
        if (lfsr_q[0]) begin
            lfsr_d = lfsr_d ^ 16'hB400;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_q <= 16'hACE1;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign imem_ready = (lfsr_q[2:0] != 3'b111);
`else
    assign imem_ready = 1'b1;
`endif

endmodule

// File: tb/tb_imem_responder.sv
// Directed bench for imem_responder: three instances (LATENCY 1, 3, 4) share one stimulus stream.
module tb_imem_responder;

    localparam logic [31:0] Base = 32'haaaaa000;
    localparam logic [31:0] Nop  = 32'h00000013;

    logic              clk = 1'b0;
    logic              rst;
    logic [31:0]       imem_addr;
    logic [3:0]        imem_rmask;
    logic              load_we;
    logic [31:0]       load_addr;
    logic [31:0]       load_wdata;
    logic [2:0]        ready;
    logic [2:0]        resp;
    logic [2:0]        err;
    logic [2:0][31:0]  rdata;

    int          checks = 0;
    int          failures = 0;
    int          lat [3];
    logic [31:0] model [16];
    logic [31:0] last_word;

    always #5 clk = ~clk;

    imem_responder #(.LATENCY(1)) u_d0 (
        .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_rmask(imem_rmask),
        .imem_ready(ready[0]), .imem_rdata(rdata[0]), .imem_resp(resp[0]),
        .load_we(load_we), .load_addr(load_addr), .load_wdata(load_wdata), .err(err[0])
    );
    imem_responder #(.LATENCY(3)) u_d1 (
        .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_rmask(imem_rmask),
        .imem_ready(ready[1]), .imem_rdata(rdata[1]), .imem_resp(resp[1]),
        .load_we(load_we), .load_addr(load_addr), .load_wdata(load_wdata), .err(err[1])
    );
    imem_responder #(.LATENCY(4)) u_d2 (
        .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_rmask(imem_rmask),
        .imem_ready(ready[2]), .imem_rdata(rdata[2]), .imem_resp(resp[2]),
        .load_we(load_we), .load_addr(load_addr), .load_wdata(load_wdata), .err(err[2])
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_word(input logic [31:0] addr, input logic [31:0] data);
        load_we    = 1'b1;
        load_addr  = addr;
        load_wdata = data;
        tick();
        load_we    = 1'b0;
    endtask

    task automatic test_reset();
        rst        = 1'b1;
        imem_rmask = 4'hf;
        imem_addr  = Base;
        tick();
        tick();
        for (int d = 0; d < 3; d++) begin
            checks += 4;
            if (resp[d] !== 1'b0) begin
                failures++;
                $display("FAIL reset_resp dut%0d: got %b expected 0", d, resp[d]);
            end
            if (rdata[d] !== 32'h0) begin
                failures++;
                $display("FAIL reset_rdata dut%0d: got %h expected 0", d, rdata[d]);
            end
            if (err[d] !== 1'b0) begin
                failures++;
                $display("FAIL reset_err dut%0d: got %b expected 0", d, err[d]);
            end
            if (ready[d] !== 1'b1) begin
                failures++;
                $display("FAIL reset_ready dut%0d: got %b expected 1", d, ready[d]);
            end
        end
        rst        = 1'b0;
        imem_rmask = 4'h0;
        tick();
    endtask

    task automatic test_preload();
        for (int i = 0; i < 16; i++) begin
            load_word(Base + 32'(i * 4), model[i]);
        end
        load_word(Base + 32'hffc, last_word);
        // Out-of-range and misaligned loads alias index 0 if the guards are wrong.
        load_word(Base + 32'h1000, 32'hBAD0BAD0);
        load_word(Base + 32'h1, 32'hBAD1BAD1);
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (err[d] !== 1'b0) begin
                failures++;
                $display("FAIL preload_err dut%0d: got %b expected 0", d, err[d]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] masks [4];
        masks = '{4'hf, 4'h1, 4'h8, 4'h3};
        for (int j = 0; j < 8; j++) begin
            imem_rmask = (j < 4) ? masks[j] : 4'h0;
            imem_addr  = Base + 32'(j * 4);
            checks++;
            if (ready !== 3'b111) begin
                failures++;
                $display("FAIL b2b_ready cycle%0d: got %b expected 111", j, ready);
            end
            tick();
            for (int d = 0; d < 3; d++) begin
                int          k;
                logic        ev;
                logic [31:0] ed;
                k  = j - (lat[d] - 1);
                ev = (k >= 0) && (k < 4);
                ed = ev ? model[k] : 32'h0;
                checks += 2;
                if (resp[d] !== ev) begin
                    failures++;
                    $display("FAIL b2b_resp dut%0d cycle%0d: got %b expected %b", d, j, resp[d], ev);
                end
                if (rdata[d] !== ed) begin
                    failures++;
                    $display("FAIL b2b_rdata dut%0d cycle%0d: got %h expected %h", d, j, rdata[d], ed);
                end
            end
        end
        checks++;
        if (err !== 3'b000) begin
            failures++;
            $display("FAIL b2b_err: got %b expected 000", err);
        end
    endtask

    task automatic test_latency();
        for (int j = 0; j < 7; j++) begin
            imem_rmask = (j == 0) ? 4'hf : 4'h0;
            imem_addr  = Base + 32'h4;
            tick();
            for (int d = 0; d < 3; d++) begin
                logic        ev;
                logic [31:0] ed;
                ev = (j == lat[d] - 1);
                ed = ev ? 32'h00100113 : 32'h0;
                checks += 2;
                if (resp[d] !== ev) begin
                    failures++;
                    $display("FAIL lat_resp dut%0d cycle%0d: got %b expected %b", d, j, resp[d], ev);
                end
                if (rdata[d] !== ed) begin
                    failures++;
                    $display("FAIL lat_rdata dut%0d cycle%0d: got %h expected %h", d, j, rdata[d], ed);
                end
            end
        end
    endtask

    task automatic test_rw_same_cycle();
        logic [31:0] exp_w [2];
        exp_w = '{32'h00208193, 32'hDEADBEEF};
        for (int j = 0; j < 7; j++) begin
            imem_rmask = (j < 2) ? 4'hf : 4'h0;
            imem_addr  = Base + 32'h8;
            load_we    = (j == 0);
            load_addr  = Base + 32'h8;
            load_wdata = 32'hDEADBEEF;
            tick();
            for (int d = 0; d < 3; d++) begin
                int          k;
                logic        ev;
                logic [31:0] ed;
                k  = j - (lat[d] - 1);
                ev = (k >= 0) && (k < 2);
                ed = ev ? exp_w[k] : 32'h0;
                checks += 2;
                if (resp[d] !== ev) begin
                    failures++;
                    $display("FAIL rw_resp dut%0d cycle%0d: got %b expected %b", d, j, resp[d], ev);
                end
                if (rdata[d] !== ed) begin
                    failures++;
                    $display("FAIL rw_rdata dut%0d cycle%0d: got %h expected %h", d, j, rdata[d], ed);
                end
            end
        end
        load_we  = 1'b0;
        model[2] = 32'hDEADBEEF;
    endtask

    task automatic test_bad();
        logic [31:0] addrs [5];
        logic [31:0] exp_w [5];
        addrs = '{Base + 32'h2, 32'h0, Base + 32'h1000, Base + 32'hffc, Base};
        exp_w = '{Nop, Nop, Nop, last_word, model[0]};
        for (int j = 0; j < 9; j++) begin
            imem_rmask = (j < 5) ? 4'hf : 4'h0;
            imem_addr  = (j < 5) ? addrs[j] : Base;
            tick();
            if (j == 0) begin
                checks++;
                if (err !== 3'b111) begin
                    failures++;
                    $display("FAIL bad_err_set: got %b expected 111", err);
                end
            end
            for (int d = 0; d < 3; d++) begin
                int          k;
                logic        ev;
                logic [31:0] ed;
                k  = j - (lat[d] - 1);
                ev = (k >= 0) && (k < 5);
                ed = ev ? exp_w[k] : 32'h0;
                checks += 2;
                if (resp[d] !== ev) begin
                    failures++;
                    $display("FAIL bad_resp dut%0d cycle%0d: got %b expected %b", d, j, resp[d], ev);
                end
                if (rdata[d] !== ed) begin
                    failures++;
                    $display("FAIL bad_rdata dut%0d cycle%0d: got %h expected %h", d, j, rdata[d], ed);
                end
            end
        end
        for (int j = 0; j < 10; j++) begin
            tick();
        end
        checks++;
        if (err !== 3'b111) begin
            failures++;
            $display("FAIL bad_err_sticky: got %b expected 111", err);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (err !== 3'b000) begin
            failures++;
            $display("FAIL bad_err_clear: got %b expected 000", err);
        end
    endtask

    task automatic test_reset_flush();
        imem_rmask = 4'hf;
        imem_addr  = Base;
        tick();
        imem_addr  = Base + 32'h4;
        tick();
        checks++;
        if (resp[0] !== 1'b1 || rdata[0] !== model[1]) begin
            failures++;
            $display("FAIL flush_pre dut0: got %b/%h expected 1/%h", resp[0], rdata[0], model[1]);
        end
        // The request held during reset must not be accepted.
        rst       = 1'b1;
        imem_addr = Base + 32'hc;
        tick();
        rst        = 1'b0;
        imem_rmask = 4'h0;
        for (int j = 0; j < 8; j++) begin
            checks += 2;
            if (resp !== 3'b000) begin
                failures++;
                $display("FAIL flush_resp cycle%0d: got %b expected 000", j, resp);
            end
            if (rdata[0] !== 32'h0 || rdata[1] !== 32'h0 || rdata[2] !== 32'h0) begin
                failures++;
                $display("FAIL flush_rdata cycle%0d: got %h %h %h expected 0", j, rdata[0], rdata[1], rdata[2]);
            end
            tick();
        end
        checks++;
        if (err !== 3'b000) begin
            failures++;
            $display("FAIL flush_err: got %b expected 000", err);
        end
        for (int j = 0; j < 6; j++) begin
            imem_rmask = (j == 0) ? 4'hf : 4'h0;
            imem_addr  = Base + 32'hc;
            tick();
            for (int d = 0; d < 3; d++) begin
                logic        ev;
                logic [31:0] ed;
                ev = (j == lat[d] - 1);
                ed = ev ? model[3] : 32'h0;
                checks++;
                if (resp[d] !== ev || rdata[d] !== ed) begin
                    failures++;
                    $display("FAIL retain dut%0d cycle%0d: got %b/%h expected %b/%h",
                             d, j, resp[d], rdata[d], ev, ed);
                end
            end
        end
    endtask

`ifdef IMEM_RANDOM_STALL_EN
    task automatic test_random_stall();
        int   r;
        int   stalls;
        int   got [3];
        logic acc;
        r      = 0;
        stalls = 0;
        got    = '{0, 0, 0};
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (got[0] == 200 && got[1] == 200 && got[2] == 200) break;
            imem_rmask = (r < 200) ? 4'hf : 4'h0;
            imem_addr  = Base + 32'((r % 16) * 4);
            acc        = (r < 200) && ready[0];
            if (!ready[0]) stalls++;
            tick();
            if (acc) r++;
            for (int d = 0; d < 3; d++) begin
                if (resp[d]) begin
                    checks++;
                    if (got[d] >= 200 || rdata[d] !== model[got[d] % 16]) begin
                        failures++;
                        $display("FAIL stall_rdata dut%0d resp%0d: got %h expected %h",
                                 d, got[d], rdata[d], model[got[d] % 16]);
                    end
                    got[d]++;
                end
            end
        end
        imem_rmask = 4'h0;
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (got[d] != 200) begin
                failures++;
                $display("FAIL stall_count dut%0d: got %0d expected 200", d, got[d]);
            end
        end
        checks++;
        if (stalls == 0) begin
            failures++;
            $display("FAIL stall_seen: got %0d stall cycles expected >0", stalls);
        end
    endtask
`endif

    initial begin
        lat        = '{1, 3, 4};
        model[0]   = 32'h00000093;
        model[1]   = 32'h00100113;
        model[2]   = 32'h00208193;
        model[3]   = 32'h00310213;
        for (int i = 4; i < 16; i++) begin
            model[i] = 32'h10000000 | 32'(i * 32'h0101);
        end
        last_word  = 32'hCAFEF00D;
        rst        = 1'b0;
        imem_addr  = 32'h0;
        imem_rmask = 4'h0;
        load_we    = 1'b0;
        load_addr  = 32'h0;
        load_wdata = 32'h0;

        test_reset();
        test_preload();
`ifdef IMEM_RANDOM_STALL_EN
        test_random_stall();
`else
        test_back_to_back();
        test_latency();
        test_rw_same_cycle();
        test_bad();
        test_reset_flush();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
